// File: rtl/count_pkg.sv
// Shared types and constants for the up/down counter family.
//   mode_t : operation performed at the last clock edge
//   MODE_W : width of the encoded mode
package count_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_LOAD = 2'd3
    } mode_t;

endpackage : count_pkg

// File: rtl/updown_next.sv
// Combinational next-value generator for a modulo / saturating counter.
// Ports:
//   q_i       : current count (0..MAX_VAL)
//   s_i       : step amount, already clamped to MAX_VAL by the caller
//   dir_i     : 1 = count up, 0 = count down
//   next_o    : count after applying the step
//   crossed_o : step went past MAX_VAL (up) or below 0 (down)
module updown_next #(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                   SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o,
    output logic             crossed_o
);

    localparam int unsigned EXT_W = WIDTH + 1;

    // One extra bit so that MAX_VAL+1 and q+s never overflow.
    logic [EXT_W-1:0] q_ext;
    logic [EXT_W-1:0] s_ext;
    logic [EXT_W-1:0] max_ext;
    logic [EXT_W-1:0] modulus;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] wrap_dn;

    assign q_ext   = {1'b0, q_i};
    assign s_ext   = {1'b0, s_i};
    assign max_ext = {1'b0, MAX_VAL};
    assign modulus = max_ext + EXT_W'(1);
    assign sum     = q_ext + s_ext;
    assign wrap_dn = q_ext + modulus - s_ext;

    // Since s <= MAX_VAL, a single modulus correction always lands in range.
    always_comb begin
        next_o    = q_i;
        crossed_o = 1'b0;
        if (dir_i) begin
            if (sum > max_ext) begin
                crossed_o = 1'b1;
                next_o    = SATURATE ? MAX_VAL : WIDTH'(sum - modulus);
            end else begin
                next_o    = WIDTH'(sum);
            end
        end else begin
            if (q_i >= s_i) begin
                next_o    = q_i - s_i;
            end else begin
                crossed_o = 1'b1;
                next_o    = SATURATE ? '0 : WIDTH'(wrap_dn);
            end
        end
    end

endmodule : updown_next

// File: rtl/updown_counter.sv
// Up/down counter with programmable modulus, per-cycle step, parallel load
// and wrap or saturate policy. Reports the operation performed and pulses tc
// for one cycle whenever a step crosses a bound.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en, dir  : count enable and direction (1 = up)
//   step     : amount added/subtracted per enabled cycle (clamped to MAX_VAL)
//   ld       : parallel load of ld_val (clamped to MAX_VAL), beats en
//   q        : registered count
//   mode     : registered operation of the last edge (mode_t)
//   tc       : registered terminal-count pulse
//   at_min   : combinational q == 0
//   at_max   : combinational q == MAX_VAL
module updown_counter
    import count_pkg::*;
#(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned          STEP_W   = 4,
    parameter bit                   SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              ld,
    input  logic [WIDTH-1:0]  ld_val,
    output logic [WIDTH-1:0]  q,
    output logic [MODE_W-1:0] mode,
    output logic              tc,
    output logic              at_min,
    output logic              at_max
);

    logic [WIDTH-1:0] q_q;
    mode_t            mode_q;
    logic             tc_q;

    logic [WIDTH-1:0] step_ext;
    logic [WIDTH-1:0] step_clamped;
    logic [WIDTH-1:0] q_load_d;
    logic [WIDTH-1:0] q_step_d;
    logic             crossed;

    // Clamp step and load value into the legal count range.
    assign step_ext     = WIDTH'(step);
    assign step_clamped = (step_ext > MAX_VAL) ? MAX_VAL : step_ext;
    assign q_load_d     = (ld_val > MAX_VAL) ? MAX_VAL : ld_val;

    updown_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .q_i       (q_q),
        .s_i       (step_clamped),
        .dir_i     (dir),
        .next_o    (q_step_d),
        .crossed_o (crossed)
    );

    // Priority mux: rst > ld > en > hold; mode records which one fired.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            mode_q <= MODE_HOLD;
            tc_q   <= 1'b0;
        end else if (ld) begin
            q_q    <= q_load_d;
            mode_q <= MODE_LOAD;
            tc_q   <= 1'b0;
        end else if (en) begin
            q_q    <= q_step_d;
            mode_q <= dir ? MODE_UP : MODE_DOWN;
            tc_q   <= crossed;
        end else begin
            mode_q <= MODE_HOLD;
            tc_q   <= 1'b0;
        end
    end

    assign q      = q_q;
    assign mode   = mode_q;
    assign tc     = tc_q;
    assign at_min = (q_q == '0);
    assign at_max = (q_q == MAX_VAL);

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances share one stimulus stream
// (decade wrap, decade saturate, full-range wrap) and are compared every
// cycle against an arithmetic model, plus literal checks on key scenarios.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] step = '0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = '0;

    logic [7:0] dq    [3];
    logic [1:0] dmode [3];
    logic       dtc   [3];
    logic       dmin  [3];
    logic       dmax  [3];

    int maxv [3] = '{9, 9, 255};
    bit satv [3] = '{1'b0, 1'b1, 1'b0};

    int mq    [3];
    bit mtc   [3];
    int mmode;
    bit valid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4), .SATURATE(1'b0)) u_w9 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .ld(ld), .ld_val(ld_val),
        .q(dq[0]), .mode(dmode[0]), .tc(dtc[0]), .at_min(dmin[0]), .at_max(dmax[0]));

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4), .SATURATE(1'b1)) u_s9 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .ld(ld), .ld_val(ld_val),
        .q(dq[1]), .mode(dmode[1]), .tc(dtc[1]), .at_min(dmin[1]), .at_max(dmax[1]));

    updown_counter #(.WIDTH(8), .MAX_VAL(8'd255), .STEP_W(4), .SATURATE(1'b0)) u_f (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .step(step), .ld(ld), .ld_val(ld_val),
        .q(dq[2]), .mode(dmode[2]), .tc(dtc[2]), .at_min(dmin[2]), .at_max(dmax[2]));

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Next count and tc from the arithmetic rules, given current inputs.
    function automatic void mdl(input int mx, input bit sat, input int cq,
                                output int nq, output bit ntc);
        int s;
        nq  = cq;
        ntc = 1'b0;
        s   = (int'(step) > mx) ? mx : int'(step);
        if (rst) begin
            nq = 0;
        end else if (ld) begin
            nq = (int'(ld_val) > mx) ? mx : int'(ld_val);
        end else if (en) begin
            if (dir) begin
                if (cq + s <= mx) nq = cq + s;
                else begin
                    ntc = 1'b1;
                    nq  = sat ? mx : cq + s - (mx + 1);
                end
            end else begin
                if (cq >= s) nq = cq - s;
                else begin
                    ntc = 1'b1;
                    nq  = sat ? 0 : cq + (mx + 1) - s;
                end
            end
        end
    endfunction

    // Model advance on every edge, then compare all instances just after.
    always @(posedge clk) begin
        int nq;
        bit ntc;
        for (int k = 0; k < 3; k++) begin
            mdl(maxv[k], satv[k], mq[k], nq, ntc);
            mq[k]  = nq;
            mtc[k] = ntc;
        end
        mmode = rst ? 0 : ld ? 3 : en ? (dir ? 1 : 2) : 0;
        if (rst) valid = 1'b1;
        #1;
        if (valid) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cyc_q[%0d]", k),    int'(dq[k]),    mq[k]);
                chk($sformatf("cyc_mode[%0d]", k), int'(dmode[k]), mmode);
                chk($sformatf("cyc_tc[%0d]", k),   int'(dtc[k]),   int'(mtc[k]));
                chk($sformatf("cyc_min[%0d]", k),  int'(dmin[k]),  int'(mq[k] == 0));
                chk($sformatf("cyc_max[%0d]", k),  int'(dmax[k]),  int'(mq[k] == maxv[k]));
            end
        end
    end

    task automatic apply(input bit r, input bit l, input int lv,
                         input bit e, input bit d, input int st);
        rst    = r;
        ld     = l;
        ld_val = 8'(lv);
        en     = e;
        dir    = d;
        step   = 4'(st);
        @(posedge clk);
        #2;
    endtask

    // Literal expectations for one instance; also pins the model's count.
    task automatic lit(input string nm, input int k, input int eq, input int emode, input int etc);
        chk({nm, "_q"},    int'(dq[k]),    eq);
        chk({nm, "_mode"}, int'(dmode[k]), emode);
        chk({nm, "_tc"},   int'(dtc[k]),   etc);
        chk({nm, "_model"}, mq[k],         eq);
    endtask

    initial begin
        @(negedge clk);
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            apply(0, ($urandom_range(0, 7) == 0), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));

        // Reset beats a simultaneous load.
        apply(1, 1, 5, 1, 1, 3);
        for (int k = 0; k < 3; k++) begin
            lit($sformatf("rst[%0d]", k), k, 0, 0, 0);
            chk($sformatf("rst_min[%0d]", k), int'(dmin[k]), 1);
            chk($sformatf("rst_max[%0d]", k), int'(dmax[k]), 0);
        end

        // Up across the decade bound.
        apply(0, 1, 8, 0, 0, 0);
        lit("ld8", 0, 8, 3, 0);
        apply(0, 0, 0, 1, 1, 3);
        lit("wup1", 0, 1, 1, 1);
        lit("sup1", 1, 9, 1, 1);
        chk("sup1_max", int'(dmax[1]), 1);
        lit("fup1", 2, 11, 1, 0);
        apply(0, 0, 0, 1, 1, 3);
        lit("wup2", 0, 4, 1, 0);
        lit("sup2", 1, 9, 1, 1);

        // Down across zero.
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 3);
        lit("wdn1", 0, 8, 2, 1);
        lit("sdn1", 1, 0, 2, 1);
        apply(0, 1, 4, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 15);
        lit("wdn15", 0, 5, 2, 1);
        lit("fdn15", 2, 245, 2, 1);
        apply(0, 1, 2, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 5);
        lit("sdn5", 1, 0, 2, 1);
        chk("sdn5_min", int'(dmin[1]), 1);

        // Load beats count, load clamps, zero step, idle.
        apply(0, 1, 200, 1, 1, 3);
        lit("ldclamp", 0, 9, 3, 0);
        lit("ld200", 2, 200, 3, 0);
        apply(0, 0, 0, 1, 1, 0);
        lit("step0", 0, 9, 1, 0);
        apply(0, 0, 0, 0, 1, 3);
        lit("idle", 0, 9, 0, 0);

        // Full-range wrap both ways.
        apply(0, 1, 255, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 1);
        lit("fwrap_up", 2, 0, 1, 1);
        lit("wwrap_up", 0, 0, 1, 1);
        apply(0, 0, 0, 1, 0, 1);
        lit("fwrap_dn", 2, 255, 2, 1);
        lit("wwrap_dn", 0, 9, 2, 1);

        // Random soak, model-checked every cycle.
        for (int i = 0; i < 3000; i++)
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 255), ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_updown_counter

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter with programmable modulus, per-cycle step size, parallel load, and a selectable wrap or saturate policy. It extends the fixed 8-bit hold/up/down counter: it reports which operation it performed and pulses a terminal-count flag. It sits in datapath control as a reusable event, address or timeout counter.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (2..32)
- MAX_VAL, 2**WIDTH-1, highest count value; legal range 1..2**WIDTH-1; the count range is 0..MAX_VAL
- STEP_W, 4, step input width; STEP_W ≤ WIDTH
- SATURATE, 0, 0 = wrap modulo MAX_VAL+1, 1 = clamp at 0 / MAX_VAL

Ports:
- clk  in  1  clock, rising edge; reset rst is synchronous, active-high
- rst  in  1  synchronous active-high reset
- en  in  1  count enable
- dir  in  1  1 = up, 0 = down (used only when en=1)
- step  in  STEP_W  increment/decrement amount per enabled cycle
- ld  in  1  parallel load request
- ld_val  in  WIDTH  load value
- q  out  WIDTH  current count, registered
- mode  out  2  operation performed at the last edge (mode_t)
- tc  out  1  terminal-count pulse, registered
- at_min  out  1  q == 0, combinational from q
- at_max  out  1  q == MAX_VAL, combinational from q

## Operation

- Priority at each rising edge is rst > ld > en > hold.
- rst: q=0, mode=HOLD, tc=0. This holds regardless of any operation in flight; no state survives reset.
- ld:
  - q = min(ld_val, MAX_VAL), mode=LOAD, tc=0.
  - en, dir and step are ignored.
- en, dir=1 (UP):
  - s = min(step, MAX_VAL). Compute sum = q + s in WIDTH+1 bits.
  - If sum ≤ MAX_VAL: q=sum, tc=0.
  - Otherwise, wrap mode: q = sum − (MAX_VAL+1). Saturate mode: q = MAX_VAL. In both cases tc=1.
- en, dir=0 (DOWN):
  - If q ≥ s: q = q − s, tc=0.
  - Otherwise, wrap mode: q = q + (MAX_VAL+1) − s. Saturate mode: q = 0. In both cases tc=1.
- step = 0 with en=1: mode is UP or DOWN, q is unchanged, tc=0.
- Saturate mode at a bound: further steps toward that bound leave q unchanged and assert tc=1 in every such cycle.
- Neither ld nor en: q holds, mode=HOLD, tc=0.
- State machine (mode_t): HOLD, UP, DOWN, LOAD. The next state is a pure function of the inputs per the priority above; any state can reach any other in one cycle. State is exposed on mode.
- Clamping step to MAX_VAL guarantees that one subtraction or addition of MAX_VAL+1 is sufficient in wrap mode.

## Timing

- All outputs except at_min and at_max are registered, with 1-cycle latency from inputs to q, mode and tc.
- at_min and at_max follow q in the same cycle.
- tc is high for exactly the cycle following the crossing edge. It is not sticky.
- Reset values: q=0, mode=HOLD, tc=0, at_min=1, at_max=0.
- ld asserted together with rst: reset wins, and ld_val is discarded.
- ld asserted together with en: load wins; no count and no tc that cycle.
- ld_val > MAX_VAL: the loaded value is clamped to MAX_VAL; tc=0.

## Structure

- Package count_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_HOLD=0, MODE_UP=1, MODE_DOWN=2, MODE_LOAD=3}
  - shared constant MODE_W=2
- Sub-module updown_next is purely combinational.
  - Inputs: q, s, dir.
  - Outputs: next value and crossed flag.
  - Parametrised by WIDTH, MAX_VAL and SATURATE, so it can be reused by future multi-channel counters.
- The top level contains the priority mux, registers, and the at_min/at_max compares.

## Test plan

- Reset: run with arbitrary activity, then assert rst one cycle together with ld=1, ld_val=5 -> next cycle q=0, mode=HOLD, tc=0, at_min=1.
- Decade wrap up (WIDTH=8, MAX_VAL=9, SATURATE=0): load 8, then en=1, dir=1, step=3 -> q=1, tc=1, mode=UP. Next cycle step=3 -> q=4, tc=0.
- Decade wrap down: load 1, then en=1, dir=0, step=3 -> q=8, tc=1. With step=15 (clamped to 9) from q=4 -> q=5, tc=1.
- Saturate (MAX_VAL=9, SATURATE=1):
  - load 8, then up with step=3 -> q=9, tc=1, at_max=1. Another up -> q=9, tc=1.
  - From q=2, down with step=5 -> q=0, tc=1, at_min=1.
- Priority and clamp:
  - ld=1, ld_val=200, en=1 (MAX_VAL=9) -> q=9, mode=LOAD, tc=0.
  - Then en=1, step=0 -> q=9, mode=UP, tc=0.
  - Then en=0 -> mode=HOLD.
- Full range (WIDTH=8, default MAX_VAL=255): from q=255, up with step=1 -> q=0, tc=1. From q=0, down with step=1 -> q=255, tc=1.
